iters_write_queue: RTL and testbench

ITERS_WRITE_QUEUE -- requirements
Module: iters_write_queue

---
 rtl/iters_write_queue.sv | 143 ++++++++++++++
 tb/tb_iters_write_queue.sv | 256 +++++++++++++++++++++++++
 2 files changed

// File: rtl/iters_write_queue.sv
// iters_write_queue: FIFO between the memory stage and the frame buffer,
// with range/overflow drop detection and a drain-then-swap frame handshake.
//
// Ports:
//   clk_in, rst_in            clock, async active-high reset
//   iters_valid_in/iters_in/addr_in   write beat in (pixel 0 in MSBs)
//   swap_req_in               one-cycle frame-swap request
//   fb_valid_out/fb_iters_out/fb_addr_out/fb_ready_in  head entry out
//   swap_out                  one-cycle swap pulse once the queue drains
//   count_out                 occupancy
//   overflow_out, range_err_out  sticky drop flags
//   dropped_count_out         dropped-beat counter
// Optional feature: define ITERS_WRITE_QUEUE_STATS_EN to enable the
// saturating dropped-beat counter (otherwise it reads 0).
module iters_write_queue #(
    parameter int FMA_COUNT  = 2,
    parameter int ITERS_BITS = 4,
    parameter int WIDTH      = 320,
    parameter int HEIGHT     = 320,
    parameter int DEPTH      = 8,
    localparam int AW = $clog2(WIDTH * HEIGHT),
    localparam int IW = ITERS_BITS * FMA_COUNT,
    localparam int CW = $clog2(DEPTH) + 1
) (
    input  logic          clk_in,
    input  logic          rst_in,
    input  logic          iters_valid_in,
    input  logic [IW-1:0] iters_in,
    input  logic [AW-1:0] addr_in,
    input  logic          swap_req_in,
    output logic          fb_valid_out,
    output logic [IW-1:0] fb_iters_out,
    output logic [AW-1:0] fb_addr_out,
    input  logic          fb_ready_in,
    output logic          swap_out,
    output logic [CW-1:0] count_out,
    output logic          overflow_out,
    output logic          range_err_out,
    output logic [15:0]   dropped_count_out
);

    localparam int PW = $clog2(DEPTH);
    localparam logic [AW-1:0] MAX_ADDR = AW'(WIDTH * HEIGHT - FMA_COUNT);

    typedef enum logic [1:0] {
        IDLE,
        DRAIN,
        SWAP
    } state_t;

    logic [IW-1:0] iters_mem_q [DEPTH];
    logic [AW-1:0] addr_mem_q  [DEPTH];
    logic [PW-1:0] wr_ptr_q, rd_ptr_q;
    logic [CW-1:0] count_q, count_d;
    logic          overflow_q, range_err_q;
    state_t        state_q, state_d;

    logic full, in_range, pop, push;

    assign full     = (count_q == CW'(DEPTH));
    assign in_range = (addr_in <= MAX_ADDR);
    assign pop      = (count_q != '0) && fb_ready_in;
    // A pop in the same cycle frees the slot a full queue needs.
    assign push     = iters_valid_in && in_range && (!full || pop);

    always_ff @(posedge clk_in) begin
        if (push) begin
            iters_mem_q[wr_ptr_q] <= iters_in;
            addr_mem_q[wr_ptr_q]  <= addr_in;
        end
    end

    always_comb begin
        count_d = count_q;
        unique case ({push, pop})
            2'b10:   count_d = count_q + CW'(1);
            2'b01:   count_d = count_q - CW'(1);
            default: count_d = count_q;
        endcase
    end

    always_ff @(posedge clk_in or posedge rst_in) begin
        if (rst_in) begin
            wr_ptr_q    <= '0;
            rd_ptr_q    <= '0;
            count_q     <= '0;
            overflow_q  <= 1'b0;
            range_err_q <= 1'b0;
        end else begin
            if (push) wr_ptr_q <= wr_ptr_q + PW'(1);
            if (pop)  rd_ptr_q <= rd_ptr_q + PW'(1);
            count_q <= count_d;
            if (iters_valid_in && !in_range) range_err_q <= 1'b1;
            if (iters_valid_in && in_range && !push) overflow_q <= 1'b1;
        end
    end

    // FSM: state register
    always_ff @(posedge clk_in or posedge rst_in) begin
        if (rst_in) state_q <= IDLE;
        else        state_q <= state_d;
    end

    // FSM: next state. Requests outside IDLE merge into the pending swap.
    always_comb begin
        state_d = state_q;
        unique case (state_q)
            IDLE:    if (swap_req_in) state_d = DRAIN;
            DRAIN:   if (count_q == '0 && !push) state_d = SWAP;
            SWAP:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    // FSM: outputs
    always_comb begin
        swap_out = (state_q == SWAP);
    end

    assign fb_valid_out  = (count_q != '0);
    assign fb_iters_out  = fb_valid_out ? iters_mem_q[rd_ptr_q] : '0;
    assign fb_addr_out   = fb_valid_out ? addr_mem_q[rd_ptr_q]  : '0;
    assign count_out     = count_q;
    assign overflow_out  = overflow_q;
    assign range_err_out = range_err_q;

`ifdef ITERS_WRITE_QUEUE_STATS_EN
    logic [15:0] dropped_q;

    always_ff @(posedge clk_in or posedge rst_in) begin
        if (rst_in) begin
            dropped_q <= '0;
        end else if (iters_valid_in && !push && dropped_q != 16'hFFFF) begin
            dropped_q <= dropped_q + 16'd1;
        end
    end

    assign dropped_count_out = dropped_q;
`else
    assign dropped_count_out = 16'd0;
`endif

endmodule

// File: tb/tb_iters_write_queue.sv
// Randomized self-checking bench for iters_write_queue with a queue-based
// reference model plus directed scenarios with literal expectations.
module tb_iters_write_queue;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        v = 1'b0;
    logic [7:0]  it = '0;
    logic [16:0] a = '0;
    logic        sreq = 1'b0;
    logic        rdy = 1'b0;
    logic        fb_valid;
    logic [7:0]  fb_iters;
    logic [16:0] fb_addr;
    logic        swp;
    logic [3:0]  cnt;
    logic        ovf;
    logic        rng;
    logic [15:0] drp;

    int n_tests = 0;
    int n_fail  = 0;

    iters_write_queue dut (
        .clk_in            (clk),
        .rst_in            (rst),
        .iters_valid_in    (v),
        .iters_in          (it),
        .addr_in           (a),
        .swap_req_in       (sreq),
        .fb_valid_out      (fb_valid),
        .fb_iters_out      (fb_iters),
        .fb_addr_out       (fb_addr),
        .fb_ready_in       (rdy),
        .swap_out          (swp),
        .count_out         (cnt),
        .overflow_out      (ovf),
        .range_err_out     (rng),
        .dropped_count_out (drp)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [16:0] ad;
        logic [7:0]  itv;
    } ent_t;

    ent_t m_q[$];
    bit   m_pend, m_swap, m_ovf, m_rng;
    int   m_drop;

    localparam int MAXA = 320 * 320 - 2;

    task automatic model_clear();
        m_q.delete();
        m_pend = 0; m_swap = 0; m_ovf = 0; m_rng = 0; m_drop = 0;
    endtask

    // One clock of the specified behaviour, from the pre-edge state.
    task automatic model_tick();
        int sz;
        bit pop, inr, acc, nswap;
        sz    = m_q.size();
        pop   = (sz > 0) && rdy;
        inr   = (int'(a) <= MAXA);
        acc   = v && inr && (sz < 8 || pop);
        nswap = 0;
        if (v && !inr) m_rng = 1;
        if (v && inr && !acc) m_ovf = 1;
`ifdef ITERS_WRITE_QUEUE_STATS_EN
        if (v && !acc && m_drop < 65535) m_drop++;
`endif
        if (m_swap) begin
        end else if (m_pend) begin
            if (sz == 0 && !acc) begin
                m_pend = 0;
                nswap  = 1;
            end
        end else if (sreq) begin
            m_pend = 1;
        end
        m_swap = nswap;
        if (pop) m_q.delete(0);
        if (acc) m_q.push_back('{ad: a, itv: it});
    endtask

    task automatic compare(input string nm);
        logic [7:0]  ei;
        logic [16:0] ea;
        ei = (m_q.size() > 0) ? m_q[0].itv : 8'd0;
        ea = (m_q.size() > 0) ? m_q[0].ad  : 17'd0;
        n_tests++;
        if (fb_valid !== (m_q.size() > 0) || fb_iters !== ei ||
            fb_addr !== ea || cnt !== 4'(m_q.size()) ||
            swp !== m_swap || ovf !== m_ovf || rng !== m_rng ||
            drp !== 16'(m_drop)) begin
            n_fail++;
            $display("FAIL %s t=%0t got v=%0d it=%h a=%0d c=%0d sw=%0d o=%0d r=%0d d=%0d want v=%0d it=%h a=%0d c=%0d sw=%0d o=%0d r=%0d d=%0d",
                     nm, $time, fb_valid, fb_iters, fb_addr, cnt, swp, ovf, rng, drp,
                     m_q.size() > 0, ei, ea, m_q.size(), m_swap, m_ovf, m_rng, m_drop);
        end
    endtask

    task automatic chk(input string nm, input longint act, input longint exp);
        n_tests++;
        if (act != exp) begin
            n_fail++;
            $display("FAIL %s got %0d want %0d", nm, act, exp);
        end
    endtask

    // Called at a negedge: drive, model, clock, then check at next negedge.
    task automatic step(input bit vv, input int aa, input int ii,
                        input bit ss, input bit rr);
        v = vv; a = 17'(aa); it = 8'(ii); sreq = ss; rdy = rr;
        model_tick();
        @(posedge clk);
        @(negedge clk);
        compare("model");
    endtask

    task automatic do_reset();
        v = 1'b1; a = '0; it = 8'hFF; sreq = 1'b1; rdy = 1'b1;
        rst = 1'b1;
        #1;
        chk("rst_async_valid", fb_valid, 0);
        chk("rst_async_count", cnt, 0);
        chk("rst_async_swap", swp, 0);
        chk("rst_async_head", {fb_iters, fb_addr}, 0);
        model_clear();
        @(posedge clk);
        @(negedge clk);
        compare("reset");
        rst = 1'b0;
        v = 1'b0; sreq = 1'b0; rdy = 1'b0;
    endtask

    int exp_drop1;
    int zc, pi, pulses;

    initial begin
`ifdef ITERS_WRITE_QUEUE_STATS_EN
        exp_drop1 = 1;
`else
        exp_drop1 = 0;
`endif
        model_clear();
        @(negedge clk);
        @(negedge clk);
        compare("reset_init");
        chk("init_count", cnt, 0);
        rst = 1'b0;

        // Single push, immediate pop
        step(1, 0, 8'hA5, 0, 1);
        chk("p1_valid", fb_valid, 1);
        chk("p1_iters", fb_iters, 8'hA5);
        chk("p1_addr", fb_addr, 0);
        step(0, 0, 0, 0, 1);
        chk("p1_count0", cnt, 0);

        // Fill to full, ninth dropped, drain in order
        for (int i = 0; i < 9; i++) step(1, 2 * i, i, 0, 0);
        chk("full_count", cnt, 8);
        chk("full_ovf", ovf, 1);
        chk("full_drop", drp, exp_drop1);
        for (int i = 0; i < 8; i++) begin
            chk("drain_addr", fb_addr, 2 * i);
            step(0, 0, 0, 0, 1);
        end
        chk("drained", cnt, 0);

        // Push while full with a pop
        do_reset();
        for (int i = 0; i < 8; i++) step(1, 4 * i, i, 0, 0);
        step(1, 500, 8'h3C, 0, 1);
        chk("pp_count", cnt, 8);
        chk("pp_ovf", ovf, 0);
        chk("pp_head", fb_addr, 4);

        // Address range boundary
        do_reset();
        step(1, 102399, 8'h11, 0, 0);
        chk("rng_flag", rng, 1);
        chk("rng_count", cnt, 0);
        step(1, 102398, 8'h22, 0, 0);
        chk("rng_ok_count", cnt, 1);
        chk("rng_ok_addr", fb_addr, 102398);

        // Empty-queue swap: pulse two cycles after request
        do_reset();
        step(0, 0, 0, 1, 0);
        chk("eswap_c1", swp, 0);
        step(0, 0, 0, 0, 0);
        chk("eswap_c2", swp, 1);
        step(0, 0, 0, 0, 0);
        chk("eswap_c3", swp, 0);

        // Swap waits for drain
        do_reset();
        for (int i = 0; i < 3; i++) step(1, 10 + 2 * i, i, 0, 0);
        step(0, 0, 0, 1, 0);
        for (int i = 0; i < 3; i++) begin
            step(0, 0, 0, i == 1, 0);
            chk("sw_hold", swp, 0);
        end
        zc = -1; pi = -1; pulses = 0;
        for (int i = 1; i <= 8; i++) begin
            step(0, 0, 0, 0, 1);
            if (cnt == 0 && zc < 0) zc = i;
            if (swp) begin
                pulses++;
                pi = i;
            end
        end
        chk("sw_pulses", pulses, 1);
        chk("sw_zero_at", zc, 3);
        chk("sw_pulse_at", pi, 4);

        // Reset mid-drain cancels swap
        do_reset();
        for (int i = 0; i < 4; i++) step(1, 2 * i, i, 0, 0);
        step(0, 0, 0, 1, 0);
        step(0, 0, 0, 0, 0);
        chk("md_count", cnt, 4);
        do_reset();
        pulses = 0;
        for (int i = 0; i < 10; i++) begin
            step(0, 0, 0, 0, 1);
            if (swp) pulses++;
        end
        chk("md_noswap", pulses, 0);

        // Randomized traffic
        for (int i = 0; i < 4000; i++) begin
            int sel, aa, rp;
            bit rr;
            sel = int'($urandom_range(0, 9));
            if (sel == 0)      aa = 102399 + int'($urandom_range(0, 20));
            else if (sel == 1) aa = 102398;
            else               aa = int'($urandom_range(0, 102398));
            rp = (i / 250) % 3;
            rr = (rp == 0) ? ($urandom_range(0, 3) == 0) :
                 (rp == 1) ? ($urandom_range(0, 1) == 0) :
                             ($urandom_range(0, 5) != 0);
            if ($urandom_range(0, 600) == 0) do_reset();
            step($urandom_range(0, 3) != 0, aa, int'($urandom_range(0, 255)),
                 $urandom_range(0, 24) == 0, rr);
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
